multiplier_core: RTL
====================

// Module: multiplier_core
// PURPOSE
//  Sequential unsigned shift-add multiplier, one partial product per clock.
//  Multiplication stage consumed by the factorial datapath controller.
//  The controller issues opstart/opclear, waits on opdone (its m_opdone), and
//  reads result back as the next running product.
// PARAMETERS
//  WIDTH  64  operand width in bits; result is 2*WIDTH; count reg $clog2(WIDTH+1) bits
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        asynchronous, active-high reset
//  opstart       in   1        start request; sampled only in IDLE
//  opclear       in   1        synchronous clear/abort; any state -> IDLE
//  multiplicand  in   WIDTH    operand A, latched on accepted start
//  multiplier    in   WIDTH    operand B, latched on accepted start
//  result        out  2*WIDTH  product; valid while opdone=1
//  opdone        out  1        high in DONE until opclear
//  busy          out  1        high in EXEC
// BEHAVIOUR
//  Reset: state=IDLE; result=0, opdone=0, busy=0; internal regs and count = 0.
//  FSM states IDLE, EXEC, DONE (2-bit encoding):
//   IDLE: opstart=1 & opclear=0 -> EXEC at edge E0.
//         At E0: mcand_r={WIDTH'0,multiplicand}, mplr_r=multiplier, result=0, count=0.
//   EXEC: every edge: if mplr_r[0], result += mcand_r (2*WIDTH-bit add, no overflow possible).
//         Then mcand_r <<= 1, mplr_r >>= 1, count++.
//         count reaching WIDTH -> DONE.
//   DONE: opdone=1, result held; opstart ignored; opclear=1 -> IDLE.
//  Latency: without early term, EXEC runs edges E1..E(WIDTH); opdone=1 and busy=0 after E(WIDTH).
//  opclear in any state (incl. mid-EXEC) -> IDLE next edge.
//   Outputs cleared: result=0, opdone=0, busy=0.
//  opclear wins over a simultaneous opstart; start is not accepted that cycle.
//  opstart while EXEC/DONE: ignored; operand inputs may change freely after E0.
//  opstart held high across DONE->IDLE: a new op starts on the first IDLE cycle with opclear=0.
//  Zero operands: multiplicand=0 or multiplier=0 -> result=0, same latency rules.
//  Async reset mid-EXEC: immediate return to IDLE with reset values; no partial result kept.
//  busy and opdone are never both high; both registered (no combinational path from inputs).
// CONFIGURATION
//  MULT_EARLY_TERM_EN defined:
//   In EXEC, if the post-shift mplr_r == 0 -> DONE on that edge.
//   Latency = index of multiplier MSB set + 1 cycles, min 1 (multiplier=0 -> 1 cycle, result 0).
//   count still bounds EXEC at WIDTH.
//  MULT_EARLY_TERM_EN undefined:
//   Fixed WIDTH-cycle EXEC regardless of operand values.
//  Result values are identical in both builds.
// TESTING
//  1. reset pulse mid-sim -> result=0, opdone=0, busy=0 asynchronously; FSM in IDLE.
//  2. 5 x 3, WIDTH=64, no macro -> opdone rises exactly 64 cycles after start edge; result=15.
//  3. FFFF_FFFF_FFFF_FFFF x FFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
//  4. start 7 x 9, opclear at EXEC cycle 10 -> IDLE next edge, result=0; restart 6 x 4 -> 24.
//  5. opstart pulsed during EXEC and in DONE -> ignored, result unchanged.
//     opclear+opstart same cycle in DONE -> IDLE, no start.
//  6. MULT_EARLY_TERM_EN, 7 x 2 -> opdone after 2 cycles, result=14.
//     Same build, 9 x 0 -> 1 cycle, result=0.

Source files
------------

// File: rtl/multiplier_core.sv
// Sequential unsigned shift-add multiplier producing one partial product per clock.
// Optional build macro MULT_EARLY_TERM_EN ends EXEC as soon as no multiplier bits remain.
module multiplier_core #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 opstart,
    input  logic                 opclear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 opdone,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplr_r;
    logic [WIDTH-1:0]     mplr_next;
    logic [CW-1:0]        count;
    logic                 last_step;

    assign mplr_next = mplr_r >> 1;

    // The count bound always applies; early termination additionally stops once the
    // shifted multiplier has no set bits left, since further steps would add nothing.
`ifdef MULT_EARLY_TERM_EN
    assign last_step = (count == CW'(WIDTH - 1)) || (mplr_next == '0);
`else
    assign last_step = (count == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mcand_r <= '0;
            mplr_r  <= '0;
            count   <= '0;
            result  <= '0;
            opdone  <= 1'b0;
            busy    <= 1'b0;
        end else if (opclear) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
            opdone <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (opstart) begin
                        mcand_r <= {{WIDTH{1'b0}}, multiplicand};
                        mplr_r  <= multiplier;
                        result  <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (mplr_r[0]) begin
                        result <= result + mcand_r;
                    end
                    mcand_r <= mcand_r << 1;
                    mplr_r  <= mplr_next;
                    count   <= count + CW'(1);
                    if (last_step) begin
                        busy   <= 1'b0;
                        opdone <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    opdone <= 1'b0;
                end
            endcase
        end
    end

endmodule
